// File: rtl/note_detector_if.sv
// note_detector_if
// Bundles the tone input and the note report of the note detector.
//   tone_in     : square-wave input (asynchronous to clk)
//   note_idx    : 0=C6 .. 6=B6, 7=none
//   note_valid  : high while a note is locked
//   note_change : one-cycle pulse when the locked note starts or changes
//   period      : last measured full period in clk cycles (saturating)
// master = the detector, slave = the tone source / report consumer.
interface note_detector_if;
  logic        tone_in;
  logic [2:0]  note_idx;
  logic        note_valid;
  logic        note_change;
  logic [15:0] period;

  modport master (
    input  tone_in,
    output note_idx,
    output note_valid,
    output note_change,
    output period
  );

  modport slave (
    output tone_in,
    input  note_idx,
    input  note_valid,
    input  note_change,
    input  period
  );
endinterface

// File: rtl/note_detector.sv
// note_detector
// Measures the full period (rise to rise) of a square wave in clk cycles and
// classifies it as one of the natural notes C6..B6. A note is locked after
// two consecutive periods classify to the same note, and dropped after one
// period that does not. If no rising edge arrives for TIMEOUT cycles the tone
// is declared absent.
// Ports:
//   clk   : system clock (50 MHz)
//   reset : synchronous, active-low reset
//   bus   : note_detector_if.master (tone_in in; note_idx, note_valid,
//           note_change, period out)
module note_detector #(
  parameter int CLK_HZ  = 50000000,
  parameter int TOL     = 256,
  parameter int TIMEOUT = 65535
) (
  input  logic               clk,
  input  logic               reset,
  note_detector_if.master    bus
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);
  localparam logic [16:0] TOL_C     = 17'(TOL);
  // The period table is only meaningful at 50 MHz; at any other clock
  // nothing classifies instead of reporting a wrong note.
  localparam logic        CLK_OK    = (CLK_HZ == 50000000);
  localparam logic [2:0]  NONE      = 3'd7;

  // Nominal full periods at 50 MHz: 2*(floor(25e6/f)+1).
  function automatic logic [16:0] nominal_of(input int i);
    case (i)
      0:       nominal_of = 17'd47756;  // C6
      1:       nominal_of = 17'd42554;  // D6
      2:       nominal_of = 17'd37908;  // E6
      3:       nominal_of = 17'd35792;  // F6
      4:       nominal_of = 17'd31888;  // G6
      5:       nominal_of = 17'd28410;  // A6
      default: nominal_of = 17'd25304;  // B6
    endcase
  endfunction

  state_t      state_reg, state_next;
  logic        s1_reg, s2_reg, s3_reg;
  logic [15:0] counter_reg, counter_next;
  logic [2:0]  cand_reg, cand_next;
  logic [2:0]  note_idx_reg, note_idx_next;
  logic        valid_reg, valid_next;
  logic        change_reg, change_next;
  logic [15:0] period_reg, period_next;

  logic        rise;
  logic [16:0] meas;
  logic [6:0]  match;
  logic [2:0]  idx;

  assign rise = s2_reg & ~s3_reg;
  assign meas = {1'b0, counter_reg};

  // One tolerance window per note; 17-bit unsigned distance, no wrap.
  for (genvar gi = 0; gi < 7; gi++) begin : g_match
    localparam logic [16:0] NOM = nominal_of(gi);
    logic [16:0] diff;
    assign diff        = (meas >= NOM) ? (meas - NOM) : (NOM - meas);
    assign match[gi]   = CLK_OK && (diff <= TOL_C);
  end

  // Lowest matching index wins.
  always_comb begin
    idx = NONE;
    for (int i = 6; i >= 0; i--) begin
      if (match[i]) idx = 3'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_reg       <= 1'b0;
      s2_reg       <= 1'b0;
      s3_reg       <= 1'b0;
      state_reg    <= IDLE;
      counter_reg  <= '0;
      cand_reg     <= NONE;
      note_idx_reg <= NONE;
      valid_reg    <= 1'b0;
      change_reg   <= 1'b0;
      period_reg   <= '0;
    end else begin
      s1_reg       <= bus.tone_in;
      s2_reg       <= s1_reg;
      s3_reg       <= s2_reg;
      state_reg    <= state_next;
      counter_reg  <= counter_next;
      cand_reg     <= cand_next;
      note_idx_reg <= note_idx_next;
      valid_reg    <= valid_next;
      change_reg   <= change_next;
      period_reg   <= period_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    counter_next  = counter_reg;
    cand_next     = cand_reg;
    note_idx_next = note_idx_reg;
    valid_next    = valid_reg;
    change_next   = 1'b0;
    period_next   = period_reg;
    case (state_reg)
      IDLE: begin
        counter_next = '0;
        // The first edge only starts the measurement.
        if (rise) begin
          state_next   = MEASURE;
          counter_next = 16'd1;
        end
      end
      MEASURE: begin
        if (rise) begin
          // An edge coinciding with the timeout still counts; TIMEOUT
          // classifies as NONE.
          counter_next = 16'd1;
          period_next  = counter_reg;
          if (idx == cand_reg && idx != NONE) begin
            note_idx_next = idx;
            valid_next    = 1'b1;
            change_next   = !valid_reg || (note_idx_reg != idx);
          end else begin
            cand_next = idx;
            if (valid_reg && idx != note_idx_reg) begin
              valid_next    = 1'b0;
              note_idx_next = NONE;
            end
          end
        end else if (counter_reg == TIMEOUT_C) begin
          state_next    = IDLE;
          counter_next  = '0;
          note_idx_next = NONE;
          valid_next    = 1'b0;
          cand_next     = NONE;
          period_next   = TIMEOUT_C;
        end else begin
          // Leaving at TIMEOUT keeps this increment from ever wrapping.
          counter_next = counter_reg + 16'd1;
        end
      end
    endcase
  end

  assign bus.note_idx    = note_idx_reg;
  assign bus.note_valid  = valid_reg;
  assign bus.note_change = change_reg;
  assign bus.period      = period_reg;

endmodule

// File: tb/tb_note_detector.sv
// tb_note_detector
// Self-checking bench for note_detector: table-driven period vectors plus
// hand-written sequences for start-up, timeout and mid-period reset.
module tb_note_detector;

  logic clk;
  logic reset;
  note_detector_if bus();

  note_detector dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          p;       // length of the period ended by the next rise
    logic [2:0]  idx;
    logic        valid;
    logic        change;
    logic [15:0] per;
  } vec_t;

  vec_t tv [24];
  int   n_tv;
  int   n_checks;
  int   n_errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string name, input logic [2:0] e_idx,
                               input logic e_valid, input logic e_change,
                               input logic [15:0] e_per);
    $display("%s: idx=%0d valid=%0d change=%0d period=%0d", name,
             bus.note_idx, bus.note_valid, bus.note_change, bus.period);
    check({name, ".note_idx"},    32'(bus.note_idx),    32'(e_idx));
    check({name, ".note_valid"},  32'(bus.note_valid),  32'(e_valid));
    check({name, ".note_change"}, 32'(bus.note_change), 32'(e_change));
    check({name, ".period"},      32'(bus.period),      32'(e_per));
  endtask

  // Called just after a posedge: raises tone_in and checks the result of
  // that rising edge (processed on the 3rd posedge), then checks that
  // note_change is low again one cycle later.
  task automatic start(input string name, input logic [15:0] e_per);
    bus.tone_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs(name, 3'd7, 1'b0, 1'b0, e_per);
    @(posedge clk);
    #1;
    check({name, ".change_end"}, 32'(bus.note_change), 32'd0);
  endtask

  // Finishes the current period so that it lasts p cycles from its rise,
  // starts the next period with a rise, and checks the outputs it produces.
  task automatic step(input string name, input int p, input logic [2:0] e_idx,
                      input logic e_valid, input logic e_change,
                      input logic [15:0] e_per);
    repeat (p / 2 - 4) @(posedge clk);
    #1;
    bus.tone_in = 1'b0;
    repeat (p - p / 2) @(posedge clk);
    #1;
    bus.tone_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs(name, e_idx, e_valid, e_change, e_per);
    @(posedge clk);
    #1;
    check({name, ".change_end"}, 32'(bus.note_change), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Lock D6, hold 10 periods, switch to A6, D6 tolerance edges, lock B6.
    n_tv = 0;
    tv[n_tv++] = '{42554, 3'd7, 1'b0, 1'b0, 16'd42554};  // candidate D6
    tv[n_tv++] = '{42554, 3'd1, 1'b1, 1'b1, 16'd42554};  // lock D6
    for (int i = 0; i < 10; i++)
      tv[n_tv++] = '{42554, 3'd1, 1'b1, 1'b0, 16'd42554};
    tv[n_tv++] = '{28410, 3'd7, 1'b0, 1'b0, 16'd28410};  // first A6 drops lock
    tv[n_tv++] = '{28410, 3'd5, 1'b1, 1'b1, 16'd28410};  // second A6 locks
    tv[n_tv++] = '{42810, 3'd7, 1'b0, 1'b0, 16'd42810};  // D6+256 drops A6
    tv[n_tv++] = '{42810, 3'd1, 1'b1, 1'b1, 16'd42810};  // D6+256 locks D6
    tv[n_tv++] = '{42298, 3'd1, 1'b1, 1'b0, 16'd42298};  // D6-256 holds
    tv[n_tv++] = '{42811, 3'd7, 1'b0, 1'b0, 16'd42811};  // D6+257 drops
    tv[n_tv++] = '{42811, 3'd7, 1'b0, 1'b0, 16'd42811};  // stays unlocked
    tv[n_tv++] = '{42297, 3'd7, 1'b0, 1'b0, 16'd42297};  // D6-257 no match
    tv[n_tv++] = '{25304, 3'd7, 1'b0, 1'b0, 16'd25304};  // candidate B6
    tv[n_tv++] = '{25304, 3'd6, 1'b1, 1'b1, 16'd25304};  // lock B6

    clk         = 1'b0;
    reset       = 1'b0;
    bus.tone_in = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 3'd7, 1'b0, 1'b0, 16'd0);
    reset = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check_outputs("idle", 3'd7, 1'b0, 1'b0, 16'd0);

    start("edge1", 16'd0);
    for (int i = 0; i < n_tv; i++)
      step($sformatf("vec%0d", i), tv[i].p, tv[i].idx, tv[i].valid,
           tv[i].change, tv[i].per);

    // Timeout: the last processed rise was 1 cycle ago; the lock must hold
    // through TIMEOUT-1 cycles and drop exactly at TIMEOUT.
    repeat (100) @(posedge clk);
    #1;
    bus.tone_in = 1'b0;
    repeat (65433) @(posedge clk);
    #1;
    check_outputs("pre_timeout", 3'd6, 1'b1, 1'b0, 16'd25304);
    @(posedge clk);
    #1;
    check_outputs("timeout", 3'd7, 1'b0, 1'b0, 16'd65535);

    // Re-lock after timeout on G6 takes three edges.
    start("relock_edge1", 16'd65535);
    step("relock_edge2", 31888, 3'd7, 1'b0, 1'b0, 16'd31888);
    step("relock_edge3", 31888, 3'd4, 1'b1, 1'b1, 16'd31888);

    // Move to E6, then reset mid-period while tone_in is low.
    step("e6_edge1", 37908, 3'd7, 1'b0, 1'b0, 16'd37908);
    step("e6_edge2", 37908, 3'd2, 1'b1, 1'b1, 16'd37908);
    repeat (37908 / 2 - 4) @(posedge clk);
    #1;
    bus.tone_in = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("mid_reset", 3'd7, 1'b0, 1'b0, 16'd0);
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_outputs("post_reset", 3'd7, 1'b0, 1'b0, 16'd0);
    start("after_reset_edge1", 16'd0);
    step("after_reset_edge2", 37908, 3'd7, 1'b0, 1'b0, 16'd37908);
    step("after_reset_edge3", 37908, 3'd2, 1'b1, 1'b1, 16'd37908);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
